reg_file_sb: RTL and testbench

REG_FILE_SB -- requirements
Module: reg_file_sb

---
 rtl/reg_file_sb.sv | 94 +++++++++
 tb/tb_reg_file_sb.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// Register file with a per-register busy (scoreboard) bit: claims mark a register
// pending, writebacks retire it. Two registered read ports with write-first bypass.
module reg_file_sb #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 8,
  parameter bit ZERO_R0 = 1'b1,
  localparam int AW     = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr_a,
  input  logic [AW-1:0]    raddr_b,
  input  logic             claim_en,
  input  logic [AW-1:0]    claim_addr,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b,
  output logic             busy_a,
  output logic             busy_b,
  output logic [DEPTH-1:0] busy_vec
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0] busy_q, busy_d;
  logic [WIDTH-1:0] rdata_a_q, rdata_a_d, rdata_b_q, rdata_b_d;
  logic             busy_a_q, busy_a_d, busy_b_q, busy_b_d;

  // Next state of the whole array; reads sample this so they see the same edge's
  // write and claim (write-first). Addresses >= DEPTH match no entry and read as 0.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    mem_d     = mem_q;
    busy_d    = busy_q;
    rdata_a_d = '0;
    rdata_b_d = '0;
    busy_a_d  = 1'b0;
    busy_b_d  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!(ZERO_R0 && i == 0)) begin
        if (we && waddr == AW'(i)) begin
          mem_d[i]  = wdata;
          busy_d[i] = 1'b0;
        end
        // Claim is applied after the write so a same-address claim wins.
        if (claim_en && claim_addr == AW'(i)) begin
          busy_d[i] = 1'b1;
        end
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (raddr_a == AW'(i)) begin
        rdata_a_d = mem_d[i];
        busy_a_d  = busy_d[i];
      end
      if (raddr_b == AW'(i)) begin
        rdata_b_d = mem_d[i];
        busy_b_d  = busy_d[i];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (reset) begin
      // NOTE: the array itself is reset here because the register contents must read 0 after reset,
      // which keeps it in flops rather than a RAM macro.
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      busy_q    <= '0;
      rdata_a_q <= '0;
      rdata_b_q <= '0;
      busy_a_q  <= 1'b0;
      busy_b_q  <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      busy_q    <= busy_d;
      rdata_a_q <= rdata_a_d;
      rdata_b_q <= rdata_b_d;
      busy_a_q  <= busy_a_d;
      busy_b_q  <= busy_b_d;
    end
  end

  assign rdata_a  = rdata_a_q;
  assign rdata_b  = rdata_b_q;
  assign busy_a   = busy_a_q;
  assign busy_b   = busy_b_q;
  assign busy_vec = busy_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: a default instance (DEPTH=8, ZERO_R0=1) and a
// DEPTH=6, ZERO_R0=0 instance share all stimulus.
module tb_reg_file_sb;

  logic        CLK = 1'b0;
  logic        reset, we, claim_en;
  logic [2:0]  waddr, raddr_a, raddr_b, claim_addr;
  logic [15:0] wdata;

  logic [15:0] rd_a, rd_b, rd6_a, rd6_b;
  logic        bz_a, bz_b, bz6_a, bz6_b;
  logic [7:0]  bv;
  logic [5:0]  bv6;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  reg_file_sb dut (
    .CLK(CLK), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .claim_en(claim_en), .claim_addr(claim_addr),
    .rdata_a(rd_a), .rdata_b(rd_b), .busy_a(bz_a), .busy_b(bz_b), .busy_vec(bv)
  );

  reg_file_sb #(.WIDTH(16), .DEPTH(6), .ZERO_R0(1'b0)) dut6 (
    .CLK(CLK), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .claim_en(claim_en), .claim_addr(claim_addr),
    .rdata_a(rd6_a), .rdata_b(rd6_b), .busy_a(bz6_a), .busy_b(bz6_b), .busy_vec(bv6)
  );

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle;
    reset    = 1'b0;
    we       = 1'b0;
    claim_en = 1'b0;
  endtask

  task automatic do_reset;
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    // Reset together with a write and a claim: reset must win.
    reset = 1'b1; we = 1'b1; waddr = 3'd3; wdata = 16'h1111;
    claim_en = 1'b1; claim_addr = 3'd3; raddr_a = 3'd3; raddr_b = 3'd3;
    tick();
    idle();
    checks++; if (rd_a !== 16'h0000) begin errors++; $display("FAIL reset_rd_a got %h exp 0000", rd_a); end
    checks++; if (rd_b !== 16'h0000) begin errors++; $display("FAIL reset_rd_b got %h exp 0000", rd_b); end
    checks++; if (bz_a !== 1'b0) begin errors++; $display("FAIL reset_bz_a got %b exp 0", bz_a); end
    checks++; if (bz_b !== 1'b0) begin errors++; $display("FAIL reset_bz_b got %b exp 0", bz_b); end
    checks++; if (bv !== 8'h00) begin errors++; $display("FAIL reset_bv got %h exp 00", bv); end
    tick();
    checks++; if (rd_a !== 16'h0000) begin errors++; $display("FAIL reset_discard_rd_a got %h exp 0000", rd_a); end
    checks++; if (bv !== 8'h00) begin errors++; $display("FAIL reset_discard_bv got %h exp 00", bv); end
  endtask

  task automatic test_write_first;
    we = 1'b1; waddr = 3'd5; wdata = 16'hBEEF; raddr_a = 3'd5; raddr_b = 3'd3;
    tick();
    we = 1'b0;
    checks++; if (rd_a !== 16'hBEEF) begin errors++; $display("FAIL wf_rd_a got %h exp beef", rd_a); end
    checks++; if (rd_b !== 16'h0000) begin errors++; $display("FAIL wf_rd_b got %h exp 0000", rd_b); end
    we = 1'b1; wdata = 16'h1234; raddr_b = 3'd5;
    tick();
    we = 1'b0;
    checks++; if (rd_a !== 16'h1234) begin errors++; $display("FAIL wf2_rd_a got %h exp 1234", rd_a); end
    checks++; if (rd_b !== 16'h1234) begin errors++; $display("FAIL wf2_rd_b got %h exp 1234", rd_b); end
    // Changing the address between edges must not disturb the registered output.
    raddr_a = 3'd3;
    #2;
    checks++; if (rd_a !== 16'h1234) begin errors++; $display("FAIL no_comb_rd_a got %h exp 1234", rd_a); end
    tick();
    checks++; if (rd_a !== 16'h0000) begin errors++; $display("FAIL rd3_rd_a got %h exp 0000", rd_a); end
    checks++; if (rd_b !== 16'h1234) begin errors++; $display("FAIL hold5_rd_b got %h exp 1234", rd_b); end
  endtask

  task automatic test_claim;
    claim_en = 1'b1; claim_addr = 3'd2; raddr_a = 3'd2;
    tick();
    claim_en = 1'b0;
    checks++; if (bz_a !== 1'b1) begin errors++; $display("FAIL claim_bz_a got %b exp 1", bz_a); end
    checks++; if (bv !== 8'h04) begin errors++; $display("FAIL claim_bv got %h exp 04", bv); end
    tick();
    checks++; if (bz_a !== 1'b1) begin errors++; $display("FAIL claim_hold_bz_a got %b exp 1", bz_a); end
    we = 1'b1; waddr = 3'd2; wdata = 16'h00AA;
    tick();
    we = 1'b0;
    checks++; if (rd_a !== 16'h00AA) begin errors++; $display("FAIL retire_rd_a got %h exp 00aa", rd_a); end
    checks++; if (bz_a !== 1'b0) begin errors++; $display("FAIL retire_bz_a got %b exp 0", bz_a); end
    checks++; if (bv !== 8'h00) begin errors++; $display("FAIL retire_bv got %h exp 00", bv); end
  endtask

  task automatic test_claim_write_same;
    claim_en = 1'b1; claim_addr = 3'd4; we = 1'b1; waddr = 3'd4; wdata = 16'h5555; raddr_a = 3'd4;
    tick();
    idle();
    checks++; if (rd_a !== 16'h5555) begin errors++; $display("FAIL same_rd_a got %h exp 5555", rd_a); end
    checks++; if (bz_a !== 1'b1) begin errors++; $display("FAIL same_bz_a got %b exp 1", bz_a); end
    checks++; if (bv !== 8'h10) begin errors++; $display("FAIL same_bv got %h exp 10", bv); end
    claim_en = 1'b1;
    tick();
    claim_en = 1'b0;
    checks++; if (bv !== 8'h10) begin errors++; $display("FAIL reclaim_bv got %h exp 10", bv); end
    we = 1'b1; wdata = 16'h6666;
    tick();
    checks++; if (bv !== 8'h00) begin errors++; $display("FAIL same_retire_bv got %h exp 00", bv); end
    wdata = 16'h7777;
    tick();
    we = 1'b0;
    checks++; if (rd_a !== 16'h7777) begin errors++; $display("FAIL nonbusy_rd_a got %h exp 7777", rd_a); end
    checks++; if (bz_a !== 1'b0) begin errors++; $display("FAIL nonbusy_bz_a got %b exp 0", bz_a); end
  endtask

  task automatic test_diff_addr;
    claim_en = 1'b1; claim_addr = 3'd6; we = 1'b1; waddr = 3'd1; wdata = 16'h0101;
    raddr_a = 3'd6; raddr_b = 3'd1;
    tick();
    idle();
    checks++; if (bz_a !== 1'b1) begin errors++; $display("FAIL diff_bz_a got %b exp 1", bz_a); end
    checks++; if (rd_a !== 16'h0000) begin errors++; $display("FAIL diff_rd_a got %h exp 0000", rd_a); end
    checks++; if (rd_b !== 16'h0101) begin errors++; $display("FAIL diff_rd_b got %h exp 0101", rd_b); end
    checks++; if (bz_b !== 1'b0) begin errors++; $display("FAIL diff_bz_b got %b exp 0", bz_b); end
    checks++; if (bv !== 8'h40) begin errors++; $display("FAIL diff_bv got %h exp 40", bv); end
    we = 1'b1; waddr = 3'd6; wdata = 16'h0606;
    tick();
    we = 1'b0;
    checks++; if (rd_a !== 16'h0606) begin errors++; $display("FAIL diff_retire_rd_a got %h exp 0606", rd_a); end
    checks++; if (bv !== 8'h00) begin errors++; $display("FAIL diff_retire_bv got %h exp 00", bv); end
  endtask

  task automatic test_zero_r0;
    do_reset();
    we = 1'b1; waddr = 3'd0; wdata = 16'hFFFF; raddr_a = 3'd0; raddr_b = 3'd0;
    tick();
    we = 1'b0; claim_en = 1'b1; claim_addr = 3'd0;
    tick();
    claim_en = 1'b0;
    tick();
    checks++; if (rd_a !== 16'h0000) begin errors++; $display("FAIL r0_rd_a got %h exp 0000", rd_a); end
    checks++; if (rd_b !== 16'h0000) begin errors++; $display("FAIL r0_rd_b got %h exp 0000", rd_b); end
    checks++; if (bz_a !== 1'b0) begin errors++; $display("FAIL r0_bz_a got %b exp 0", bz_a); end
    checks++; if (bv !== 8'h00) begin errors++; $display("FAIL r0_bv got %h exp 00", bv); end
    // The ZERO_R0=0 instance treats register 0 as ordinary.
    checks++; if (rd6_a !== 16'hFFFF) begin errors++; $display("FAIL r0_plain_rd_a got %h exp ffff", rd6_a); end
    checks++; if (bz6_a !== 1'b1) begin errors++; $display("FAIL r0_plain_bz_a got %b exp 1", bz6_a); end
    checks++; if (bv6 !== 6'h01) begin errors++; $display("FAIL r0_plain_bv got %h exp 01", bv6); end
  endtask

  task automatic test_out_of_range;
    do_reset();
    we = 1'b1; waddr = 3'd7; wdata = 16'h7777; claim_en = 1'b1; claim_addr = 3'd7;
    raddr_a = 3'd7; raddr_b = 3'd6;
    tick();
    idle();
    checks++; if (rd_a !== 16'h7777) begin errors++; $display("FAIL oor_d8_rd_a got %h exp 7777", rd_a); end
    checks++; if (bv !== 8'h80) begin errors++; $display("FAIL oor_d8_bv got %h exp 80", bv); end
    checks++; if (rd6_a !== 16'h0000) begin errors++; $display("FAIL oor_rd_a got %h exp 0000", rd6_a); end
    checks++; if (bz6_a !== 1'b0) begin errors++; $display("FAIL oor_bz_a got %b exp 0", bz6_a); end
    checks++; if (rd6_b !== 16'h0000) begin errors++; $display("FAIL oor_rd_b got %h exp 0000", rd6_b); end
    checks++; if (bv6 !== 6'h00) begin errors++; $display("FAIL oor_bv got %h exp 00", bv6); end
    raddr_a = 3'd5; raddr_b = 3'd0;
    tick();
    checks++; if (rd6_a !== 16'h0000) begin errors++; $display("FAIL oor_alias_rd_a got %h exp 0000", rd6_a); end
    checks++; if (rd6_b !== 16'h0000) begin errors++; $display("FAIL oor_alias_rd_b got %h exp 0000", rd6_b); end
  endtask

  task automatic test_reset_mid;
    do_reset();
    we = 1'b1;
    waddr = 3'd1; wdata = 16'h0011; tick();
    waddr = 3'd2; wdata = 16'h0022; tick();
    waddr = 3'd3; wdata = 16'h0033; tick();
    we = 1'b0; claim_en = 1'b1;
    claim_addr = 3'd1; tick();
    claim_addr = 3'd2; tick();
    claim_addr = 3'd3; raddr_a = 3'd1; raddr_b = 3'd3; tick();
    claim_en = 1'b0;
    checks++; if (bv !== 8'h0E) begin errors++; $display("FAIL mid_bv got %h exp 0e", bv); end
    checks++; if (bv6 !== 6'h0E) begin errors++; $display("FAIL mid_bv6 got %h exp 0e", bv6); end
    checks++; if (rd_a !== 16'h0011) begin errors++; $display("FAIL mid_rd_a got %h exp 0011", rd_a); end
    checks++; if (bz_b !== 1'b1) begin errors++; $display("FAIL mid_bz_b got %b exp 1", bz_b); end
    reset = 1'b1; we = 1'b1; waddr = 3'd1; wdata = 16'hDEAD; claim_en = 1'b1; claim_addr = 3'd5;
    tick();
    idle();
    checks++; if (bv !== 8'h00) begin errors++; $display("FAIL mid_rst_bv got %h exp 00", bv); end
    checks++; if (bv6 !== 6'h00) begin errors++; $display("FAIL mid_rst_bv6 got %h exp 00", bv6); end
    checks++; if (rd_a !== 16'h0000) begin errors++; $display("FAIL mid_rst_rd_a got %h exp 0000", rd_a); end
    tick();
    checks++; if (rd_a !== 16'h0000) begin errors++; $display("FAIL mid_discard_rd_a got %h exp 0000", rd_a); end
    checks++; if (rd_b !== 16'h0000) begin errors++; $display("FAIL mid_discard_rd_b got %h exp 0000", rd_b); end
    checks++; if (bz_a !== 1'b0) begin errors++; $display("FAIL mid_discard_bz_a got %b exp 0", bz_a); end
    // First edge after reset already accepts a write.
    we = 1'b1; waddr = 3'd3; wdata = 16'h3333;
    tick();
    we = 1'b0;
    checks++; if (rd_b !== 16'h3333) begin errors++; $display("FAIL post_rst_rd_b got %h exp 3333", rd_b); end
  endtask

  initial begin
    idle();
    waddr = '0; wdata = '0; raddr_a = '0; raddr_b = '0; claim_addr = '0;
    test_reset();
    test_write_first();
    test_claim();
    test_claim_write_same();
    test_diff_addr();
    test_zero_r0();
    test_out_of_range();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
